// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, fixed 33-cycle start-to-done latency for every op.
module muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned DW    = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             ready_q, busy_q, done_q;

    // Operand pre-processing: signedness per funct3, then magnitudes
    logic            a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0] mag_a_c, mag_b_c;

    assign a_sgn_c = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                     (op == 3'b100) || (op == 3'b110);
    assign b_sgn_c = (op == 3'b000) || (op == 3'b001) ||
                     (op == 3'b100) || (op == 3'b110);
    assign a_neg_c = a_sgn_c && a[XLEN-1];
    assign b_neg_c = b_sgn_c && b[XLEN-1];
    assign mag_a_c = a_neg_c ? (XLEN'(0) - a) : a;
    assign mag_b_c = b_neg_c ? (XLEN'(0) - b) : b;

    // One iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
    logic            is_div_c;
    logic [XLEN:0]   mul_sum_c;
    logic [XLEN:0]   div_shift_c;
    logic            div_ok_c;
    logic [XLEN-1:0] div_sub_c;
    logic [XLEN-1:0] hi_it_c, lo_it_c;

    assign is_div_c    = op_q[2];
    assign mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
    assign div_shift_c = {hi_q, lo_q[XLEN-1]};
    assign div_ok_c    = (div_shift_c >= {1'b0, opnd_q});
    assign div_sub_c   = div_shift_c[XLEN-1:0] - opnd_q;
    assign hi_it_c     = is_div_c ? (div_ok_c ? div_sub_c : div_shift_c[XLEN-1:0])
                                  : mul_sum_c[XLEN:1];
    assign lo_it_c     = is_div_c ? {lo_q[XLEN-2:0], div_ok_c}
                                  : {mul_sum_c[0], lo_q[XLEN-1:1]};

    // Sign fix-up of the final product / quotient / remainder
    logic [DW-1:0]   prod_c, prod_s_c;
    logic [XLEN-1:0] quot_s_c, rem_s_c, final_c;

    assign prod_c   = {hi_it_c, lo_it_c};
    assign prod_s_c = neg_q ? (DW'(0) - prod_c) : prod_c;
    assign quot_s_c = neg_q ? (XLEN'(0) - lo_it_c) : lo_it_c;
    assign rem_s_c  = neg_q ? (XLEN'(0) - hi_it_c) : hi_it_c;

    always_comb begin
        final_c = prod_s_c[XLEN-1:0];
        case (op_q)
            3'b000:                 final_c = prod_s_c[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_c = prod_s_c[DW-1:XLEN];
            3'b100, 3'b101:         final_c = quot_s_c;
            default:                final_c = rem_s_c;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        logic accept;
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = start && !flush;
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = hi_it_c;
                    lo_d  = lo_it_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d  = S_DONE;
                        result_d = final_c;
                    end
                end
            end
            S_DONE: begin
                accept  = start && !flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            op_d    = op;
            hi_d    = '0;
            if (op[2]) begin
                lo_d   = mag_a_c;
                opnd_d = mag_b_c;
                // Quotient of a divide-by-zero stays all-ones; remainder follows the dividend
                neg_d  = op[1] ? a_neg_c : ((a_neg_c ^ b_neg_c) && (b != '0));
            end else begin
                lo_d   = mag_b_c;
                opnd_d = mag_a_c;
                neg_d  = a_neg_c ^ b_neg_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            ready_q  <= (state_d != S_CALC);
            busy_q   <= (state_d == S_CALC);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
- Takes the same register operands a and b as the ALU and produces a 32-bit result for the same writeback mux.
- Fixed-latency start/done handshake, so the pipeline controller stalls deterministically.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation (equals XLEN).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand, latched on accept
- b  input  32  rs2 operand, latched on accept
- flush  input  1  synchronous abort of the in-flight operation
- ready  output  1  unit can accept start this cycle
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- result  output  32  result; held until the next accepted start

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset (any state, including mid-operation) gives: state=IDLE, ready=1, busy=0, done=0, result=0, counter=0. No done is produced for an aborted operation.
- States: IDLE, CALC, DONE.
  - IDLE: ready=1. start=1 latches op, a, b, pre-processes the operands, counter=0, and moves to CALC.
  - CALC: busy=1, ready=0. One iteration per cycle; counter increments. After iteration 32 (counter==31) move to DONE and register result.
  - DONE: done=1, ready=1. start=1 goes back to CALC (back-to-back); otherwise go to IDLE.
- Latency:
  - Start accepted on edge k.
  - Iterations occur on edges k+1..k+32.
  - done is high for exactly the one cycle after edge k+32.
  - Latency is identical for all ops and all operand values, including special cases.
- start while ready=0 is ignored.
- a, b and op changes after accept have no effect.
- flush:
  - In CALC: go to IDLE next edge; done not asserted; result unchanged.
  - In DONE: done still shows this cycle; next state is IDLE; a simultaneous start is not accepted.
  - In IDLE: no effect.
  - flush and start in the same IDLE cycle: flush wins and start is dropped.
  - reset has priority over flush.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Method: iterate on magnitudes; negate the final product/quotient/remainder as required.
  - Remainder takes the sign of the dividend.
- Multiply:
  - 64-bit product.
  - MUL returns bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32] of the correctly signed product.
- Divide by zero (b==0):
  - DIV/DIVU: result=0xFFFFFFFF.
  - REM/REMU: result=a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF):
  - DIV: result=0x80000000.
  - REM: result=0.
- Special cases still take the full 33-cycle latency.
- busy = (state==CALC). ready = (state!=CALC).

Test Plan:
- Reset, then start MUL a=7 b=0xFFFFFFFD -> done exactly 33 cycles after the start cycle, result=0xFFFFFFEB; busy high for 32 cycles.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Each case takes 33 cycles.
- Back-to-back: start held high in the DONE cycle with new op DIVU 9/3 -> second done 33 cycles later with result=3. start pulses during CALC are ignored.
- flush at iteration 10 -> no done pulse; result keeps its previous value; ready=1 the next cycle. reset mid-CALC -> result=0, ready=1, done never asserted.
